// File: rtl/float_pkg.sv
// Shared binary64 constants and the converter FSM encoding used by the
// integer-to-double front end and float_addsub.
package float_pkg;

  localparam int unsigned DBL_BIAS   = 1023;
  localparam int unsigned DBL_EXP_W  = 11;
  localparam int unsigned DBL_FRAC_W = 52;
  localparam int unsigned DBL_MANT_W = DBL_FRAC_W + 1;

  // Biased exponent of a 64-bit magnitude whose leading one sits at bit 63.
  localparam logic [DBL_EXP_W-1:0] DBL_EXP_INT64 = DBL_EXP_W'(DBL_BIAS + 63);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_OUT
  } conv_state_t;

endpackage

// File: rtl/float_rne_round.sv
// Round-to-nearest-even of a left-justified 64-bit mantissa to a 53-bit
// significand, packed as a binary64 word together with an inexact flag.
module float_rne_round
  import float_pkg::*;
(
  input  logic [63:0]          i_mant,
  input  logic [DBL_EXP_W-1:0] i_exp,
  input  logic                 i_sign,
  output logic [63:0]          o_data,
  output logic                 o_inexact
);

  localparam int unsigned LSB = 64 - DBL_MANT_W;

  logic [DBL_MANT_W-1:0] w_sig;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_round_up;
  logic [DBL_MANT_W:0]   w_sum;
  logic [DBL_EXP_W-1:0]  w_exp;
  logic [DBL_FRAC_W-1:0] w_frac;

  assign w_sig      = i_mant[63:LSB];
  assign w_guard    = i_mant[LSB-1];
  assign w_sticky   = |i_mant[LSB-2:0];
  assign w_round_up = w_guard & (w_sticky | i_mant[LSB]);

  assign w_sum  = {1'b0, w_sig} + {{DBL_MANT_W{1'b0}}, w_round_up};
  // On carry-out the sum is exactly 2^53, so the low fraction bits are already zero.
  assign w_frac = w_sum[DBL_FRAC_W-1:0];

  // A mantissa with no leading one (zero) packs with a zero exponent field.
  always_comb begin
    w_exp = '0;
    if (w_sum[DBL_MANT_W]) begin
      w_exp = i_exp + DBL_EXP_W'(1);
    end else if (w_sum[DBL_MANT_W-1]) begin
      w_exp = i_exp;
    end
  end

  assign o_data    = {i_sign, w_exp, w_frac};
  assign o_inexact = w_guard | w_sticky;

endmodule

// File: rtl/int64_to_float.sv
// Sequential 64-bit integer to binary64 converter: coarse/fine left-shift
// normalisation, RNE rounding, result held until the consumer takes it.
module int64_to_float
  import float_pkg::*;
#(
  parameter bit          SIGNED     = 1'b1,
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_inexact
);

  conv_state_t          r_state;
  conv_state_t          w_state_nxt;
  logic [63:0]          r_mag;
  logic [63:0]          w_mag_nxt;
  logic [DBL_EXP_W-1:0] r_exp;
  logic [DBL_EXP_W-1:0] w_exp_nxt;
  logic                 r_sign;
  logic                 w_sign_nxt;
  logic [63:0]          r_out_data;
  logic [63:0]          w_out_data_nxt;
  logic                 r_out_inexact;
  logic                 w_out_inexact_nxt;

  logic                 w_in_neg;
  logic [63:0]          w_in_mag;
  logic                 w_coarse;
  logic [63:0]          w_rnd_data;
  logic                 w_rnd_inexact;

  assign w_in_neg = SIGNED & in_data[63];
  // Negating -2^63 wraps back to 0x8000_0000_0000_0000, the correct magnitude.
  assign w_in_mag = w_in_neg ? (~in_data + 64'd1) : in_data;
  assign w_coarse = (r_mag[63 -: SHIFT_STEP] == '0);

  assign in_ready    = (r_state == ST_IDLE) && !rst;
  assign out_valid   = (r_state == ST_OUT);
  assign out_data    = r_out_data;
  assign out_inexact = r_out_inexact;

  float_rne_round u_round (
    .i_mant    (r_mag),
    .i_exp     (r_exp),
    .i_sign    (r_sign),
    .o_data    (w_rnd_data),
    .o_inexact (w_rnd_inexact)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_mag_nxt         = r_mag;
    w_exp_nxt         = r_exp;
    w_sign_nxt        = r_sign;
    w_out_data_nxt    = r_out_data;
    w_out_inexact_nxt = r_out_inexact;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          w_sign_nxt = w_in_neg;
          w_mag_nxt  = w_in_mag;
          w_exp_nxt  = DBL_EXP_INT64;
          if (w_in_mag == '0) begin
            w_out_data_nxt    = '0;
            w_out_inexact_nxt = 1'b0;
            w_state_nxt       = ST_OUT;
          end else begin
            w_state_nxt = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (r_mag[63]) begin
          w_state_nxt = ST_ROUND;
        end else if (w_coarse) begin
          w_mag_nxt = r_mag << SHIFT_STEP;
          w_exp_nxt = r_exp - DBL_EXP_W'(SHIFT_STEP);
        end else begin
          w_mag_nxt = r_mag << 1;
          w_exp_nxt = r_exp - DBL_EXP_W'(1);
        end
      end
      ST_ROUND: begin
        w_out_data_nxt    = w_rnd_data;
        w_out_inexact_nxt = w_rnd_inexact;
        w_state_nxt       = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mag         <= '0;
      r_exp         <= '0;
      r_sign        <= 1'b0;
      r_out_data    <= '0;
      r_out_inexact <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mag         <= w_mag_nxt;
      r_exp         <= w_exp_nxt;
      r_sign        <= w_sign_nxt;
      r_out_data    <= w_out_data_nxt;
      r_out_inexact <= w_out_inexact_nxt;
    end
  end

endmodule

// File: tb/tb_int64_to_float.sv
// Directed-vector bench for int64_to_float: one signed and one unsigned
// instance, hand-computed doubles, latency, backpressure and reset abort.
module tb_int64_to_float;

  logic        clk = 1'b0;
  logic        rst;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_inexact;
  logic [63:0] s_in_data, s_out_data;
  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_out_inexact;
  logic [63:0] u_in_data, u_out_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  int64_to_float #(.SIGNED(1'b1), .SHIFT_STEP(8)) u_dut_s (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (s_in_valid),
    .in_ready    (s_in_ready),
    .in_data     (s_in_data),
    .out_valid   (s_out_valid),
    .out_ready   (s_out_ready),
    .out_data    (s_out_data),
    .out_inexact (s_out_inexact)
  );

  int64_to_float #(.SIGNED(1'b0), .SHIFT_STEP(8)) u_dut_u (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (u_in_valid),
    .in_ready    (u_in_ready),
    .in_data     (u_in_data),
    .out_valid   (u_out_valid),
    .out_ready   (u_out_ready),
    .out_data    (u_out_data),
    .out_inexact (u_out_inexact)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // exp_lat counts clock edges after the accepting edge until out_valid is seen;
  // a zero input reaches OUT on the accepting edge itself (exp_lat = 0).
  task automatic convert(input bit uns, input logic [63:0] din, input logic [63:0] exp_d,
                         input logic exp_x, input int exp_lat, input int stall);
    int n;
    @(negedge clk);
    check("rdy_pre", 64'(uns ? u_in_ready : s_in_ready), 64'd1);
    if (uns) begin u_in_valid = 1'b1; u_in_data = din; end
    else     begin s_in_valid = 1'b1; s_in_data = din; end
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    u_in_valid = 1'b0;
    n = 0;
    while (!(uns ? u_out_valid : s_out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("data", uns ? u_out_data : s_out_data, exp_d);
    check("inexact", 64'(uns ? u_out_inexact : s_out_inexact), 64'(exp_x));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 64'(uns ? u_out_valid : s_out_valid), 64'd1);
      check("bp_data", uns ? u_out_data : s_out_data, exp_d);
      check("bp_inexact", 64'(uns ? u_out_inexact : s_out_inexact), 64'(exp_x));
      check("bp_in_ready", 64'(uns ? u_in_ready : s_in_ready), 64'd0);
    end
    if (uns) u_out_ready = 1'b1; else s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    u_out_ready = 1'b0;
    s_out_ready = 1'b0;
    check("handoff_valid", 64'(uns ? u_out_valid : s_out_valid), 64'd0);
    check("handoff_ready", 64'(uns ? u_in_ready : s_in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit seen_valid;
    rst = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    u_in_valid = 1'b0; u_in_data = '0; u_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(s_out_valid), 64'd0);
    check("rst_data", s_out_data, 64'd0);
    check("rst_inexact", 64'(s_out_inexact), 64'd0);
    check("rst_in_ready", 64'(s_in_ready), 64'd0);
    check("rst_u_valid", 64'(u_out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(s_in_ready), 64'd1);

    // Signed instance: small values, negatives, most negative, rounding ties.
    convert(1'b0, 64'd10,                   64'h4024_0000_0000_0000, 1'b0, 13, 0);
    convert(1'b0, 64'hFFFF_FFFF_FFFF_FFF6,  64'hC024_0000_0000_0000, 1'b0, 13, 0);
    convert(1'b0, 64'hFFFF_FFFF_FFFF_FFFF,  64'hBFF0_0000_0000_0000, 1'b0, 16, 0);
    convert(1'b0, 64'h8000_0000_0000_0000,  64'hC3E0_0000_0000_0000, 1'b0, 2,  0);
    convert(1'b0, 64'h0020_0000_0000_0001,  64'h4340_0000_0000_0000, 1'b1, 5,  0);
    convert(1'b0, 64'h0020_0000_0000_0003,  64'h4340_0000_0000_0002, 1'b1, 5,  0);

    // Unsigned instance: all-ones rounds up into the next binade; zero.
    convert(1'b1, 64'hFFFF_FFFF_FFFF_FFFF,  64'h43F0_0000_0000_0000, 1'b1, 2,  0);
    convert(1'b1, 64'd0,                    64'h0000_0000_0000_0000, 1'b0, 0,  0);
    convert(1'b1, 64'd1,                    64'h3FF0_0000_0000_0000, 1'b0, 16, 0);

    // Backpressure: hold the result for 20 cycles before taking it.
    convert(1'b0, 64'd10,                   64'h4024_0000_0000_0000, 1'b0, 13, 20);

    // Reset while in NORM drops the conversion.
    @(negedge clk);
    check("abort_rdy_pre", 64'(s_in_ready), 64'd1);
    s_in_valid = 1'b1;
    s_in_data  = 64'd1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_rdy_in_rst", 64'(s_in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_rdy_after", 64'(s_in_ready), 64'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (s_out_valid) seen_valid = 1'b1;
    end
    check("abort_no_valid", 64'(seen_valid), 64'd0);
    convert(1'b0, 64'd10,                   64'h4024_0000_0000_0000, 1'b0, 13, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
